// File: rtl/demux41_pkg.sv
// Shared definitions for the 4:1 deserializer and its transmit-side partner.
// DEMUX41_PARITY_EN selects the 5-slot frame with a trailing even-parity slot.
package demux41_pkg;

`ifdef DEMUX41_PARITY_EN
  localparam int SLOTS  = 5;
  localparam int SLOT_W = 3;
`else
  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;
`endif

  localparam int WORD_W = 4;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/demux41_deser_if.sv
// Link-side bundle of the deserializer: serial input, marker, slot index and word outputs.
// With DEMUX41_PARITY_EN the bundle also carries parity_slot.
interface demux41_deser_if;
  import demux41_pkg::*;

  logic              din;
  logic              sync;
  logic [1:0]        sel;
  logic [WORD_W-1:0] q;
  logic              valid;
  logic              err;
  logic              locked;
`ifdef DEMUX41_PARITY_EN
  logic              parity_slot;

  modport master (output din, output sync,
                  input sel, input q, input valid, input err, input locked, input parity_slot);
  modport slave  (input din, input sync,
                  output sel, output q, output valid, output err, output locked, output parity_slot);
`else
  modport master (output din, output sync,
                  input sel, input q, input valid, input err, input locked);
  modport slave  (input din, input sync,
                  output sel, output q, output valid, output err, output locked);
`endif

endinterface

// File: rtl/demux41_deser_slot_prescaler.sv
// Slot-rate prescaler: cnt runs 0..DIV-1 and tick marks the last clock of each slot.
// Shared with the transmit mux so both ends step slots on the same clock.
module slot_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (cnt == LAST) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/demux41_deser.sv
// Receive end of the 4:1 time-multiplexed link: slot stepping, marker alignment, word rebuild.
// Define DEMUX41_PARITY_EN for a 5-slot frame whose last slot carries even parity.
module demux41_deser
  import demux41_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  demux41_deser_if.slave bus
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

  logic tick;

  state_t            state_q,  state_d;
  logic [SLOT_W-1:0] slot_q,   slot_d;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic [WORD_W-1:0] q_q,      q_d;
  logic              valid_q,  valid_d;
  logic              err_q,    err_d;

  slot_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      shadow_q <= '0;
      q_q      <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      q_q      <= q_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Everything advances only on slot ticks; valid/err fall back to 0 otherwise.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    q_d      = q_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    if (tick) begin
      if (state_q == HUNT) begin
        if (bus.sync) begin
          shadow_d = {{(WORD_W-1){1'b0}}, bus.din};
          slot_d   = SLOT_ONE;
          state_d  = LOCKED;
        end
      end else if (slot_q == '0) begin
        if (bus.sync) begin
          shadow_d = {{(WORD_W-1){1'b0}}, bus.din};
          slot_d   = SLOT_ONE;
        end else begin
          err_d    = 1'b1;
          shadow_d = '0;
          slot_d   = '0;
          state_d  = HUNT;
        end
      end else if (bus.sync) begin
        // Early marker: drop the partial frame and restart with this sample as slot 0.
        err_d    = 1'b1;
        shadow_d = {{(WORD_W-1){1'b0}}, bus.din};
        slot_d   = SLOT_ONE;
`ifdef DEMUX41_PARITY_EN
      end else if (slot_q == LAST_SLOT) begin
        if (bus.din == even_parity(shadow_q)) begin
          q_d     = shadow_q;
          valid_d = 1'b1;
        end else begin
          err_d   = 1'b1;
        end
        shadow_d = '0;
        slot_d   = '0;
`else
      end else if (slot_q == LAST_SLOT) begin
        q_d      = {bus.din, shadow_q[WORD_W-2:0]};
        valid_d  = 1'b1;
        shadow_d = '0;
        slot_d   = '0;
`endif
      end else begin
        shadow_d[slot_q[1:0]] = bus.din;
        slot_d                = slot_q + SLOT_ONE;
      end
    end
  end

  assign bus.sel    = slot_q[1:0];
  assign bus.q      = q_q;
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;
  assign bus.locked = (state_q == LOCKED);
`ifdef DEMUX41_PARITY_EN
  assign bus.parity_slot = (slot_q == 3'd4);
`endif

endmodule

// File: tb/tb_demux41_deser.sv
// Scoreboard bench for demux41_deser: directed frames, then randomized slots against a frame-level model.
// Builds for both the plain and DEMUX41_PARITY_EN configurations.
module tb_demux41_deser;
  import demux41_pkg::*;

`ifdef DEMUX41_PARITY_EN
  localparam int DIV = 1;
`else
  localparam int DIV = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux41_deser_if bus ();

  demux41_deser #(.DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [3:0] q;
    int         stamp;
  } ev_t;

  ev_t exp_q[$];
  int  tests  = 0;
  int  fails  = 0;
  int  edge_n = 0;

  always @(posedge clk) edge_n++;

  // Frame-level reference: a list of bits collected since the last marker.
  bit         m_locked;
  int         m_pos;
  bit         m_bits[$];
  logic [3:0] m_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input bit is_err);
    ev_t e;
    e.is_err = is_err;
    e.q      = m_q;
    e.stamp  = edge_n;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_pos    = 0;
    m_bits.delete();
    m_q      = 4'd0;
  endtask

  task automatic model_tick(input bit d, input bit s);
    logic [3:0] word;
    if (!m_locked) begin
      if (s) begin
        m_locked = 1'b1;
        m_bits.delete();
        m_bits.push_back(d);
        m_pos = 1;
      end
    end else if (m_pos == 0) begin
      if (s) begin
        m_bits.delete();
        m_bits.push_back(d);
        m_pos = 1;
      end else begin
        push_ev(1'b1);
        m_locked = 1'b0;
        m_bits.delete();
      end
    end else if (s) begin
      push_ev(1'b1);
      m_bits.delete();
      m_bits.push_back(d);
      m_pos = 1;
    end else begin
      m_bits.push_back(d);
      m_pos++;
      if (m_pos == SLOTS) begin
        word = 4'd0;
        for (int i = 0; i < 4; i++) word[i] = m_bits[i];
`ifdef DEMUX41_PARITY_EN
        if (m_bits[4] == bit'($countones(word) % 2)) begin
          m_q = word;
          push_ev(1'b0);
        end else begin
          push_ev(1'b1);
        end
`else
        m_q = word;
        push_ev(1'b0);
`endif
        m_pos = 0;
        m_bits.delete();
      end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_sel"}, 32'(bus.sel), 32'(m_pos % 4));
    check({tag, "_locked"}, 32'(bus.locked), 32'(m_locked));
`ifdef DEMUX41_PARITY_EN
    check({tag, "_parity_slot"}, 32'(bus.parity_slot), 32'(m_pos == 4));
`endif
  endtask

  // Present one slot's inputs and advance to just after its sampling edge.
  task automatic do_tick(input bit d, input bit s);
    bus.din  = d;
    bus.sync = s;
    repeat (DIV) @(posedge clk);
    #1;
    model_tick(d, s);
    check_state("tick");
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    check("rst_q", 32'(bus.q), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send_frame(input logic [3:0] w);
    for (int i = 0; i < 4; i++) do_tick(w[i], i == 0);
`ifdef DEMUX41_PARITY_EN
    do_tick(^w, 1'b0);
`endif
  endtask

`ifdef DEMUX41_PARITY_EN
  task automatic send_frame_par(input logic [3:0] w, input bit par);
    for (int i = 0; i < 4; i++) do_tick(w[i], i == 0);
    do_tick(par, 1'b0);
  endtask
`endif

  // Monitor: every valid/err pulse must match the oldest expected event on its cycle.
  always @(negedge clk) begin
    if (bus.valid || bus.err) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: valid=%b err=%b q=%h, nothing expected (t=%0t)",
                 bus.valid, bus.err, bus.q, $time);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_kind", 32'({bus.valid, bus.err}), e.is_err ? 32'd1 : 32'd2);
        check("event_q", 32'(bus.q), 32'(e.q));
        check("event_cycle", 32'(edge_n), 32'(e.stamp));
      end
    end else if (exp_q.size() > 0 && exp_q[0].stamp <= edge_n) begin
      ev_t e;
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_event: got no pulse, expected %s with q=%h at edge %0d (t=%0t)",
               e.is_err ? "err" : "valid", e.q, e.stamp, $time);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.din  = 1'b0;
    bus.sync = 1'b0;
    model_reset();

    do_reset(3);

    // HUNT ignores unmarked slots.
    for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b0);

    // First tick lands DIV edges after release; one edge earlier nothing has moved.
    do_reset(1);
    bus.din  = 1'b1;
    bus.sync = 1'b1;
    repeat (DIV - 1) @(posedge clk);
    #1;
    check("pre_tick_locked", 32'(bus.locked), 32'd0);
    @(posedge clk);
    #1;
    model_tick(1'b1, 1'b1);
    check_state("first_tick");
    check("first_tick_sel_one", 32'(bus.sel), 32'd1);

    // Finish frame 1,0,1,1 then send 0,1,1,0.
    do_tick(1'b0, 1'b0);
    do_tick(1'b1, 1'b0);
    do_tick(1'b1, 1'b0);
`ifdef DEMUX41_PARITY_EN
    do_tick(1'b1, 1'b0);
`endif
    check("frame1_q", 32'(bus.q), 32'h d);
    send_frame(4'b0110);
    check("frame2_q", 32'(bus.q), 32'h6);

    // Early marker at slot 2, then slots 1..3 complete the restarted frame.
    do_tick(1'b0, 1'b1);
    do_tick(1'b0, 1'b0);
    do_tick(1'b1, 1'b1);
    check("early_sel", 32'(bus.sel), 32'd1);
    do_tick(1'b0, 1'b0);
    do_tick(1'b1, 1'b0);
    do_tick(1'b0, 1'b0);
`ifdef DEMUX41_PARITY_EN
    do_tick(1'b0, 1'b0);
`endif
    check("early_q", 32'(bus.q), 32'h5);

    // Missing marker drops lock.
    do_tick(1'b1, 1'b0);
    check("missing_locked", 32'(bus.locked), 32'd0);

    // Reset in the middle of a frame.
    do_tick(1'b1, 1'b1);
    do_tick(1'b1, 1'b0);
    do_reset(1);

`ifdef DEMUX41_PARITY_EN
    send_frame_par(4'b1011, 1'b1);
    check("parity_ok_q", 32'(bus.q), 32'hb);
    send_frame_par(4'b1011, 1'b0);
    check("parity_bad_q", 32'(bus.q), 32'hb);
    check("parity_bad_locked", 32'(bus.locked), 32'd1);
`endif

    // Random slots: mostly well-placed markers, occasional misplaced ones and resets.
    for (int i = 0; i < 400; i++) begin
      bit s;
      s = (m_pos == 0);
      if ($urandom_range(0, 7) == 0) s = !s;
      if ($urandom_range(0, 99) == 0) do_reset(int'($urandom_range(1, 2)));
      else do_tick(bit'($urandom_range(0, 1)), s);
    end

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
